// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: FSM encoding, field widths and the MEM->WB record shared by the memory stage.
package mem_stage_pkg;
  localparam int DW = 32;
  localparam int WCW = 4;
  localparam int MXW = 2;
  typedef enum logic {IDLE, ACCESS} state_t;
  typedef struct packed {
    logic valid;
    logic [WCW-1:0] wc;
    logic [DW-1:0] pc;
    logic [DW-1:0] pr;
    logic [DW-1:0] alu_res;
    logic [MXW-1:0] s_mxrb;
    logic w_rb;
  } wb_t;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM->WB pipeline register with synchronous active-low clear and load enable.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  wb_t  d,
  output wb_t  q
);
  always_ff @(posedge clk)
    if (!rst_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage, stalls upstream while a load/store waits for the data-memory ack.
// Define MEM_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES unacknowledged cycles.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic           in_clk,
  input  logic           in_rst_n,
  input  logic           in_valid,
  input  logic [WCW-1:0] in_WC,
  input  logic [DW-1:0]  in_PC,
  input  logic [DW-1:0]  in_alu_res,
  input  logic [DW-1:0]  in_store_data,
  input  logic           in_RD,
  input  logic           in_WR,
  input  logic [MXW-1:0] in_S_MXRB,
  input  logic           in_W_RB,
  output logic           out_dm_req,
  output logic           out_dm_we,
  output logic [DW-1:0]  out_dm_addr,
  output logic [DW-1:0]  out_dm_wdata,
  input  logic [DW-1:0]  in_dm_rdata,
  input  logic           in_dm_ack,
  output logic           out_valid,
  output logic [WCW-1:0] out_WC,
  output logic [DW-1:0]  out_PC,
  output logic [DW-1:0]  out_PR,
  output logic [DW-1:0]  out_alu_res,
  output logic [MXW-1:0] out_S_MXRB,
  output logic           out_W_RB,
  output logic           out_stall,
  output logic           out_bus_err
);
  state_t state, nxt;
  logic start, ack, to, done;
  wb_t d, q;
  assign start = state == IDLE && in_valid && (in_RD || in_WR);
  assign ack = state == ACCESS && in_dm_ack;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic bus_err;
  assign to = state == ACCESS && !in_dm_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge in_clk) begin
    cnt <= (!in_rst_n || state == IDLE) ? '0 : cnt + 1'b1;
    bus_err <= in_rst_n && to;
  end
  assign out_bus_err = bus_err;
`else
  assign to = 1'b0;
  assign out_bus_err = 1'b0;
`endif
  // A timed-out access still retires, so upstream must be released on that cycle too
  assign done = state == IDLE ? in_valid && !start : ack || to;
  assign out_stall = start || (state == ACCESS && !done);
  always_comb nxt = start ? ACCESS : (state == ACCESS && done) ? IDLE : state;
  always_ff @(posedge in_clk)
    if (!in_rst_n) begin
      state <= IDLE;
      out_dm_req <= 1'b0;
      out_dm_we <= 1'b0;
      out_dm_addr <= '0;
      out_dm_wdata <= '0;
    end else begin
      state <= nxt;
      if (start) begin
        out_dm_req <= 1'b1;
        out_dm_we <= in_WR;
        out_dm_addr <= in_alu_res;
        out_dm_wdata <= in_store_data;
      end else if (state == ACCESS && done) out_dm_req <= 1'b0;
    end
  // Bubbles are fully zeroed so idle WB outputs stay deterministic
  always_comb begin
    d = '0;
    if (done) begin
      d.valid = 1'b1;
      d.wc = in_WC;
      d.pc = in_PC;
      d.pr = (ack && in_RD && !in_WR) ? in_dm_rdata : '0;
      d.alu_res = in_alu_res;
      d.s_mxrb = in_S_MXRB;
      d.w_rb = in_W_RB && !to;
    end
  end
  mem_wb_reg u_wb (.clk(in_clk), .rst_n(in_rst_n), .en(1'b1), .d(d), .q(q));
  assign out_valid = q.valid;
  assign out_WC = q.wc;
  assign out_PC = q.pc;
  assign out_PR = q.pr;
  assign out_alu_res = q.alu_res;
  assign out_S_MXRB = q.s_mxrb;
  assign out_W_RB = q.w_rb;
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: ACCESS cycles without ack before abort (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have one clock and a synchronous, active-low reset: in_clk input 1, rising-edge clock; in_rst_n input 1, synchronous active-low reset.
REQ-003 SHALL have these EX-side inputs, width in bits:
- in_valid, 1: instruction present.
- in_WC, 4: write-back register index.
- in_PC, 32: instruction PC.
- in_alu_res, 32: ALU result, also the memory address.
- in_store_data, 32: store operand.
- in_RD, 1: load.
- in_WR, 1: store.
- in_S_MXRB, 2: write-back mux select.
- in_W_RB, 1: register write enable.
REQ-004 SHALL have these data-memory ports:
- out_dm_req, output 1: request.
- out_dm_we, output 1: write.
- out_dm_addr, output 32: address.
- out_dm_wdata, output 32: write data.
- in_dm_rdata, input 32: read data.
- in_dm_ack, input 1: transfer done.
REQ-005 SHALL have these registered WB-side outputs:
- out_valid, 1.
- out_WC, 4.
- out_PC, 32.
- out_PR, 32: load data.
- out_alu_res, 32.
- out_S_MXRB, 2.
- out_W_RB, 1.
REQ-006 SHALL have control outputs out_stall (1, holds upstream stages) and out_bus_err (1, abort pulse).

Function
REQ-007 SHALL implement FSM states IDLE and ACCESS.
REQ-008 IDLE, in_valid=1, in_RD=in_WR=0: SHALL register all in_* fields to the WB outputs next edge (latency 1), with out_PR=0 and out_stall=0.
REQ-009 IDLE, in_valid=0: SHALL register a bubble next edge (out_valid=0, out_W_RB=0; other outputs don't-care but deterministic).
REQ-010 IDLE, in_valid=1 with in_RD or in_WR: SHALL assert out_stall combinationally, enter ACCESS next edge, and register out_dm_req=1, out_dm_addr=in_alu_res, out_dm_wdata=in_store_data, out_dm_we=in_WR.
REQ-011 in_RD=in_WR=1 SHALL be handled as a store; out_PR=0.
REQ-012 In ACCESS, req/we/addr/wdata SHALL stay stable until the ack edge; out_stall=!in_dm_ack; WB outputs SHALL carry a bubble each wait cycle.
REQ-013 in_dm_ack SHALL be sampled only in ACCESS; an ack in IDLE SHALL be ignored.
REQ-014 On ack in ACCESS, the next edge SHALL:
- drop out_dm_req;
- return to IDLE;
- register the instruction fields with out_valid=1 and out_PR=in_dm_rdata for a load, 0 for a store.
REQ-015 Memory-instruction latency SHALL be 2 + N cycles, where N is the number of wait cycles before ack; back-to-back ack (N=0) SHALL give 2.
REQ-016 The upstream stage SHALL hold in_* stable while out_stall=1; the block SHALL NOT latch the EX fields a second time.

Reset
REQ-017 On an edge with in_rst_n=0, the block SHALL:
- set state IDLE;
- clear all registered outputs to 0;
- clear the timeout counter.
REQ-018 Reset during ACCESS SHALL drop out_dm_req at that edge; the pending access SHALL be discarded, with no WB write.

Configuration
REQ-019 With MEM_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles. At TIMEOUT_CYCLES without ack, the next edge SHALL:
- drop out_dm_req;
- pulse out_bus_err for 1 cycle;
- register out_valid=1 with out_W_RB=0;
- return to IDLE.
REQ-020 An ack on the same cycle as the timeout SHALL win, giving a normal completion.
REQ-021 Without MEM_TIMEOUT_EN, there SHALL be no counter, out_bus_err SHALL be tied 0, and ACCESS SHALL wait indefinitely.

Structure
REQ-022 A shared package SHALL hold the FSM state encoding and the width constants (32 data/address bits, 4 WC bits, 2 S_MXRB bits).
REQ-023 One sub-module SHALL exist, mem_wb_reg: the reset/enable-able MEM->WB pipeline register.

Verification
REQ-024 ALU op: in_valid=1, WC=3, alu_res=0x10 -> next cycle out_valid=1, out_WC=3, out_alu_res=0x10, out_PR=0, no stall.
REQ-025 Load, addr 0x100, ack after 3 wait cycles, rdata 0xDEADBEEF:
- out_dm_req high 4 cycles;
- stall 4 cycles;
- then out_PR=0xDEADBEEF, out_valid=1.
REQ-026 Store with zero-wait ack -> out_dm_we=1, wdata matches in_store_data, 2-cycle latency, out_PR=0.
REQ-027 Reset asserted mid-ACCESS, then ack arrives -> out_dm_req=0 after the reset edge, ack ignored, outputs stay 0.
REQ-028 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> out_bus_err pulses once, out_W_RB=0, FSM returns to IDLE; without the macro, stall persists.
